// File: rtl/button_counter.sv
// Three debounced pushbuttons (up, down, clear) driving a small wrapping counter.
// Each button: polarity fix, two-flop synchronizer, debounce FSM emitting one-cycle press/release pulses.
module button_counter #(
  parameter int         LOG2DEBOUNCE = 16,
  parameter int         BITS         = 5,
  parameter logic [2:0] INV_MASK     = 3'b000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      btn_raw,
  output logic [2:0]      btn_state,
  output logic [2:0]      press,
  output logic [2:0]      release_o,
  output logic [BITS-1:0] count
);

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } btn_fsm_e;

  logic [2:0] sync1_q;
  logic [2:0] sync2_q;

  // Polarity is corrected before the synchronizer so every stage sees 1 = pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw ^ INV_MASK;
      sync2_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      btn_fsm_e                state_q;
      btn_fsm_e                state_d;
      logic [LOG2DEBOUNCE-1:0] cnt_q;
      logic [LOG2DEBOUNCE-1:0] cnt_d;
      logic                    press_q;
      logic                    press_d;
      logic                    release_q;
      logic                    release_d;

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q   <= RELEASED;
          cnt_q     <= '0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
        end else begin
          state_q   <= state_d;
          cnt_q     <= cnt_d;
          press_q   <= press_d;
          release_q <= release_d;
        end
      end

      // Any agreeing sample restarts the window; only a full run of disagreement flips the state.
      always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync2_q[gi] != (state_q == PRESSED)) begin
          if (&cnt_q) begin
            if (state_q == PRESSED) begin
              state_d   = RELEASED;
              release_d = 1'b1;
            end else begin
              state_d = PRESSED;
              press_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      assign btn_state[gi] = (state_q == PRESSED);
      assign press[gi]     = press_q;
      assign release_o[gi] = release_q;
    end
  endgenerate

  logic [BITS-1:0] count_q;
  logic [BITS-1:0] count_d;

  // Clear beats everything; simultaneous up and down cancel.
  always_comb begin
    count_d = count_q;
    if (press[2]) begin
      count_d = '0;
    end else if (press[0] && !press[1]) begin
      count_d = count_q + 1'b1;
    end else if (press[1] && !press[0]) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_button_counter.sv
// Bench for button_counter: directed scenarios plus random button activity, checked against
// a timestamp-based reference model of two instances (normal polarity and btn_raw[0] inverted).
module tb_button_counter;

  localparam int L2D = 4;
  localparam int WIN = 1 << L2D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] raw_a, raw_b;
  logic [2:0] st_a, pr_a, rl_a, st_b, pr_b, rl_b;
  logic [4:0] cnt_a, cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  button_counter #(.LOG2DEBOUNCE(L2D), .BITS(5), .INV_MASK(3'b000)) dut_a (
    .clk(clk), .rst(rst), .btn_raw(raw_a), .btn_state(st_a),
    .press(pr_a), .release_o(rl_a), .count(cnt_a)
  );

  button_counter #(.LOG2DEBOUNCE(L2D), .BITS(5), .INV_MASK(3'b001)) dut_b (
    .clk(clk), .rst(rst), .btn_raw(raw_b), .btn_state(st_b),
    .press(pr_b), .release_o(rl_b), .count(cnt_b)
  );

  // Reference model: a button flips once its sampled level has differed from the
  // debounced level for WIN consecutive edges, measured from the edge it last changed.
  int         m_edge = 0;
  logic [2:0] m_d1[2], m_d2[2], m_st[2], m_pr[2], m_rl[2];
  logic [2:0] n_d1[2], n_st[2], n_pr[2], n_rl[2];
  int         m_since[2][3], n_since[2][3];
  int         m_cnt[2], n_cnt[2];

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      n_d1[d] = (d == 0) ? raw_a : (raw_b ^ 3'b001);
      n_st[d] = m_st[d];
      n_pr[d] = '0;
      n_rl[d] = '0;
      for (int i = 0; i < 3; i++) begin
        n_since[d][i] = (m_d1[d][i] != m_d2[d][i]) ? m_edge + 1 : m_since[d][i];
        if (m_d2[d][i] != m_st[d][i] && (m_edge - m_since[d][i]) == WIN - 1) begin
          n_st[d][i] = m_d2[d][i];
          n_pr[d][i] = m_d2[d][i];
          n_rl[d][i] = ~m_d2[d][i];
        end
      end
      n_cnt[d] = m_cnt[d];
      if (m_pr[d][2]) n_cnt[d] = 0;
      else if (m_pr[d][0] && !m_pr[d][1]) n_cnt[d] = (m_cnt[d] + 1) % 32;
      else if (m_pr[d][1] && !m_pr[d][0]) n_cnt[d] = (m_cnt[d] + 31) % 32;
    end
  end

  always @(posedge clk) begin
    m_edge <= m_edge + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_d1[d]  <= '0;
        m_d2[d]  <= '0;
        m_st[d]  <= '0;
        m_pr[d]  <= '0;
        m_rl[d]  <= '0;
        m_cnt[d] <= 0;
        for (int i = 0; i < 3; i++) m_since[d][i] <= m_edge;
      end else begin
        m_d1[d]  <= n_d1[d];
        m_d2[d]  <= m_d1[d];
        m_st[d]  <= n_st[d];
        m_pr[d]  <= n_pr[d];
        m_rl[d]  <= n_rl[d];
        m_cnt[d] <= n_cnt[d];
        for (int i = 0; i < 3; i++) m_since[d][i] <= n_since[d][i];
      end
    end
  end

  logic [27:0] dut_vec, mdl_vec;
  assign dut_vec = {st_a, pr_a, rl_a, cnt_a, st_b, pr_b, rl_b, cnt_b};
  assign mdl_vec = {m_st[0], m_pr[0], m_rl[0], 5'(m_cnt[0]),
                    m_st[1], m_pr[1], m_rl[1], 5'(m_cnt[1])};

  // Stimulus only: press the given buttons of instance A, hold, then let go.
  task automatic hold_raw(input logic [2:0] bits, input int cycles);
    raw_a = raw_a | bits;
    repeat (cycles) @(negedge clk);
    raw_a = raw_a & ~bits;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    raw_a = 3'b000;
    raw_b = 3'b001;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({st_a, pr_a, rl_a, cnt_a} !== 14'd0)
        $display("FAIL reset_hold: got %h required 0", {st_a, pr_a, rl_a, cnt_a});
      else n_pass++;
    end
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      n_checks++;
      if ({st_a, pr_a, rl_a, cnt_a} !== 14'd0 || dut_vec !== mdl_vec)
        $display("FAIL reset_idle: dut %h model %h", dut_vec, mdl_vec);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    raw_a[0] = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      n_checks++;
      if (pr_a[0] !== (k == 17) || st_a[0] !== (k >= 17) ||
          cnt_a !== ((k >= 18) ? 5'd1 : 5'd0) || dut_vec !== mdl_vec)
        $display("FAIL clean_press k=%0d: press=%b state=%b count=%0d model %h", k, pr_a[0], st_a[0], cnt_a, mdl_vec);
      else n_pass++;
    end
    raw_a[0] = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      n_checks++;
      if (rl_a[0] !== (k == 17) || st_a[0] !== (k < 17) || pr_a !== 3'b000 ||
          cnt_a !== 5'd1 || dut_vec !== mdl_vec)
        $display("FAIL clean_release k=%0d: release=%b state=%b count=%0d required count 1", k, rl_a[0], st_a[0], cnt_a);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    for (int r = 0; r < 5; r++) begin
      int hi;
      hi = (r == 0) ? 10 : $urandom_range(1, WIN - 1);
      for (int c = 0; c < hi + 3; c++) begin
        raw_a[1] = (c < hi);
        @(negedge clk);
        n_checks++;
        if (pr_a[1] !== 1'b0 || st_a[1] !== 1'b0 || cnt_a !== 5'd1 || dut_vec !== mdl_vec)
          $display("FAIL glitch hi=%0d: press=%b state=%b count=%0d required 0/0/1", hi, pr_a[1], st_a[1], cnt_a);
        else n_pass++;
      end
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (st_a !== 3'b000 || cnt_a !== 5'd1)
      $display("FAIL glitch_settle: state=%b count=%0d required 000/1", st_a, cnt_a);
    else n_pass++;
  endtask

  task automatic test_wrap();
    hold_raw(3'b100, 20);
    n_checks++;
    if (cnt_a !== 5'd0 || dut_vec !== mdl_vec)
      $display("FAIL wrap_clear: count=%0d required 0", cnt_a);
    else n_pass++;
    hold_raw(3'b010, $urandom_range(18, 25));
    n_checks++;
    if (cnt_a !== 5'd31 || dut_vec !== mdl_vec)
      $display("FAIL wrap_down: count=%0d required 31", cnt_a);
    else n_pass++;
    repeat (32) hold_raw(3'b001, $urandom_range(18, 25));
    n_checks++;
    if (cnt_a !== 5'd31 || dut_vec !== mdl_vec)
      $display("FAIL wrap_32up: count=%0d required 31", cnt_a);
    else n_pass++;
    hold_raw(3'b001, 20);
    n_checks++;
    if (cnt_a !== 5'd0 || dut_vec !== mdl_vec)
      $display("FAIL wrap_up: count=%0d required 0", cnt_a);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    raw_a = 3'b011;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      n_checks++;
      if (pr_a !== ((k == 17) ? 3'b011 : 3'b000) || cnt_a !== 5'd0 || dut_vec !== mdl_vec)
        $display("FAIL up_down k=%0d: press=%b count=%0d required count 0", k, pr_a, cnt_a);
      else n_pass++;
    end
    raw_a = 3'b000;
    repeat (20) @(negedge clk);
    repeat (7) hold_raw(3'b001, 20);
    n_checks++;
    if (cnt_a !== 5'd7)
      $display("FAIL seven_ups: count=%0d required 7", cnt_a);
    else n_pass++;
    raw_a = 3'b111;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      n_checks++;
      if (pr_a !== ((k == 17) ? 3'b111 : 3'b000) ||
          cnt_a !== ((k >= 18) ? 5'd0 : 5'd7) || dut_vec !== mdl_vec)
        $display("FAIL all_three k=%0d: press=%b count=%0d", k, pr_a, cnt_a);
      else n_pass++;
    end
    raw_a = 3'b000;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    raw_a[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++;
      if (pr_a !== 3'b000 || st_a[0] !== 1'b0 || dut_vec !== mdl_vec)
        $display("FAIL mid_window k=%0d: press=%b state=%b", k, pr_a, st_a[0]);
      else n_pass++;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      n_checks++;
      if (pr_a[0] !== (k == 17) || cnt_a !== ((k >= 18) ? 5'd1 : 5'd0) || dut_vec !== mdl_vec)
        $display("FAIL after_reset k=%0d: press=%b count=%0d", k, pr_a[0], cnt_a);
      else n_pass++;
    end
    raw_a[0] = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_polarity();
    repeat (30) begin
      @(negedge clk);
      n_checks++;
      if (pr_b !== 3'b000 || st_b !== 3'b000 || dut_vec !== mdl_vec)
        $display("FAIL inv_idle: press=%b state=%b required 000/000", pr_b, st_b);
      else n_pass++;
    end
    raw_b[0] = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      n_checks++;
      if (pr_b[0] !== (k == 17) || cnt_b !== ((k >= 18) ? 5'd1 : 5'd0) || dut_vec !== mdl_vec)
        $display("FAIL inv_press k=%0d: press=%b count=%0d", k, pr_b[0], cnt_b);
      else n_pass++;
    end
    raw_b[0] = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    for (int r = 0; r < 200; r++) begin
      int hold;
      raw_a    = 3'($urandom_range(0, 3));
      raw_a[2] = ($urandom_range(0, 9) == 0);
      raw_b    = 3'($urandom_range(0, 7));
      hold     = $urandom_range(1, 40);
      repeat (hold) begin
        @(negedge clk);
        n_checks++;
        if (dut_vec !== mdl_vec)
          $display("FAIL random r=%0d: dut %h model %h", r, dut_vec, mdl_vec);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_polarity();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
